// File: rtl/tomasula_types.sv
// Shared types for the Tomasulo front end: operation class and the decoded
// control word carried from decode through the instruction queue to dispatch.
package tomasula_types;

  typedef enum logic [3:0] {
    NOP    = 4'd0,
    ALU    = 4'd1,
    ALUI   = 4'd2,
    LOAD   = 4'd3,
    STORE  = 4'd4,
    BRANCH = 4'd5,
    JAL    = 4'd6,
    JALR   = 4'd7,
    LUI    = 4'd8
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
  } control_word;

endpackage

// File: rtl/iq_2_ir.sv
// Decoder-to-instruction-queue handshake: decoder holds ld_iq and the word
// stable until the queue answers with ack_o in the same cycle.
interface IQ_2_IR;

  logic                        ld_iq;
  tomasula_types::control_word control_word;
  logic                        ack_o;

  modport IQ_SIG (input ld_iq, input control_word, output ack_o);
  modport IR_SIG (output ld_iq, output control_word, input ack_o);

endinterface

// File: rtl/instruction_queue.sv
// Circular FIFO between decode and dispatch: one push and one pop per cycle,
// oldest entry presented combinationally, single-cycle flush.
module instruction_queue
  import tomasula_types::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  IQ_2_IR.IQ_SIG           iq_ir_itf,
  input  logic             flush_ip,
  input  logic             deq_rdy,
  output logic             deq_valid,
  output control_word      deq_word,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  control_word      q [DEPTH];
  logic             push;
  logic             pop;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // rst is folded in so ack_o reads 0 while reset is held, even with ld_iq up
  assign push            = rst & iq_ir_itf.ld_iq & ~full & ~flush_ip;
  assign iq_ir_itf.ack_o = push;

  assign deq_valid = ~empty;
  assign deq_word  = q[head];
  assign pop       = deq_valid & deq_rdy & ~flush_ip;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_ip) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage holds no control state, so it is left out of reset
  always_ff @(posedge clk) begin
    if (push) q[tail] <= iq_ir_itf.control_word;
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: vector table for fill/refuse plus
// hand-written sequences for reset, latency, wrap-around and flush.
module tb_instruction_queue;
  import tomasula_types::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_ip = 1'b0;
  logic        deq_rdy = 1'b0;
  logic        deq_valid;
  control_word deq_word;
  logic        full;
  logic        empty;
  logic [3:0]  count;

  IQ_2_IR iq_if ();

  instruction_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .iq_ir_itf (iq_if),
    .flush_ip  (flush_ip),
    .deq_rdy   (deq_rdy),
    .deq_valid (deq_valid),
    .deq_word  (deq_word),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  control_word sb[$];

  typedef struct {
    logic        ld;
    logic [31:0] pc;
    logic        rdy;
    logic        e_ack;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_full;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic control_word mkw(input logic [31:0] pc, input op_t op);
    control_word w;
    w.op  = op;
    w.rd  = pc[6:2];
    w.rs1 = pc[7:3];
    w.rs2 = pc[8:4];
    w.imm = ~pc;
    w.pc  = pc;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    logic        exp_ack;
    logic        popped;
    control_word w;

    // Fill 8, refuse the 9th, no bypass while full, ack resumes after a pop
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 32'(4*(i+1)), 1'b0, 1'b1, (i > 0), 32'h04, 1'b0, 4'(i+1)};
    vecs[8]  = '{1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 4'd8};
    vecs[9]  = '{1'b1, 32'h24, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 4'd7};
    vecs[10] = '{1'b1, 32'h24, 1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 4'd8};
    vecs[11] = '{1'b0, 32'h28, 1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 4'd8};

    iq_if.ld_iq = 1'b1;
    iq_if.control_word = mkw(32'h0, NOP);
    #2;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(deq_valid), 32'd0);
    chk("reset_ack", 32'(iq_if.ack_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    iq_if.ld_iq = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      iq_if.ld_iq = vecs[i].ld;
      iq_if.control_word = mkw(vecs[i].pc, ALU);
      deq_rdy = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_ack", i), 32'(iq_if.ack_o), 32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_valid", i), 32'(deq_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      if (vecs[i].e_valid)
        chk($sformatf("vec%0d_pc", i), deq_word.pc, vecs[i].e_pc);
      tick();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
    end

    // Pop three to reach count 5, then reset asynchronously mid-cycle
    iq_if.ld_iq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      deq_rdy = 1'b1;
      #1;
      chk("pre_reset_pop_pc", deq_word.pc, 32'(8 + 4*k));
      tick();
    end
    deq_rdy = 1'b0;
    chk("pre_reset_count", 32'(count), 32'd5);
    iq_if.ld_iq = 1'b1;
    rst = 1'b0;
    #1;
    chk("async_reset_empty", 32'(empty), 32'd1);
    chk("async_reset_count", 32'(count), 32'd0);
    chk("async_reset_valid", 32'(deq_valid), 32'd0);
    chk("async_reset_ack", 32'(iq_if.ack_o), 32'd0);
    iq_if.ld_iq = 1'b0;
    rst = 1'b1;
    tick();

    // Empty latency: no flow-through
    w = mkw(32'h200, JALR);
    iq_if.ld_iq = 1'b1;
    iq_if.control_word = w;
    #1;
    chk("lat_push_valid", 32'(deq_valid), 32'd0);
    chk("lat_push_ack", 32'(iq_if.ack_o), 32'd1);
    tick();
    sb.push_back(w);
    iq_if.ld_iq = 1'b0;
    #1;
    chk("lat_next_valid", 32'(deq_valid), 32'd1);
    chk("lat_next_op", 32'(deq_word.op), 32'(JALR));
    chk("lat_next_pc", deq_word.pc, 32'h200);

    for (int k = 1; k < 3; k++) begin
      w = mkw(32'(32'h200 + 4*k), ALUI);
      iq_if.ld_iq = 1'b1;
      iq_if.control_word = w;
      #1;
      chk("fill3_ack", 32'(iq_if.ack_o), 32'd1);
      tick();
      sb.push_back(w);
    end
    iq_if.ld_iq = 1'b0;
    chk("fill3_count", 32'(count), 32'd3);

    // Simultaneous push and pop holds occupancy while the head advances
    for (int k = 0; k < 10; k++) begin
      w = mkw(32'(32'h300 + 4*k), LOAD);
      iq_if.ld_iq = 1'b1;
      iq_if.control_word = w;
      deq_rdy = 1'b1;
      #1;
      chk("pp_ack", 32'(iq_if.ack_o), 32'd1);
      chk("pp_head_pc", deq_word.pc, sb[0].pc);
      tick();
      void'(sb.pop_front());
      sb.push_back(w);
      chk("pp_count", 32'(count), 32'd3);
    end

    // Random dispatch readiness across pointer wrap-around
    n = 0;
    for (int cyc = 0; cyc < 400 && (n < 20 || sb.size() != 0); cyc++) begin
      w = mkw(32'(32'h400 + 4*n), STORE);
      iq_if.ld_iq = (n < 20);
      iq_if.control_word = w;
      deq_rdy = 1'($urandom_range(0, 1));
      #1;
      exp_ack = (n < 20) && (sb.size() < DEPTH);
      popped = 1'b0;
      chk("wrap_ack", 32'(iq_if.ack_o), 32'(exp_ack));
      chk("wrap_valid", 32'(deq_valid), 32'(sb.size() != 0));
      if (sb.size() != 0 && deq_rdy) begin
        chk("wrap_pop_pc", deq_word.pc, sb[0].pc);
        popped = 1'b1;
      end
      tick();
      if (popped) void'(sb.pop_front());
      if (exp_ack) begin
        sb.push_back(w);
        n++;
      end
      chk("wrap_count", 32'(count), 32'(sb.size()));
      chk("wrap_count_le_depth", 32'(count <= DEPTH), 32'd1);
    end
    chk("wrap_done", 32'(n == 20 && sb.size() == 0), 32'd1);
    iq_if.ld_iq = 1'b0;
    deq_rdy = 1'b0;

    // Flush with six entries, decoder and dispatch both active
    for (int k = 0; k < 6; k++) begin
      iq_if.ld_iq = 1'b1;
      iq_if.control_word = mkw(32'(32'h500 + 4*k), BRANCH);
      #1;
      chk("pre_flush_ack", 32'(iq_if.ack_o), 32'd1);
      tick();
    end
    chk("pre_flush_count", 32'(count), 32'd6);
    flush_ip = 1'b1;
    deq_rdy = 1'b1;
    iq_if.control_word = mkw(32'h600, ALU);
    #1;
    chk("flush1_ack", 32'(iq_if.ack_o), 32'd0);
    chk("flush1_valid", 32'(deq_valid), 32'd1);
    tick();
    chk("flush1_count", 32'(count), 32'd0);
    chk("flush1_empty", 32'(empty), 32'd1);
    #1;
    chk("flush2_ack", 32'(iq_if.ack_o), 32'd0);
    tick();
    chk("flush2_count", 32'(count), 32'd0);
    flush_ip = 1'b0;
    deq_rdy = 1'b0;
    iq_if.control_word = mkw(32'h100, JAL);
    #1;
    chk("post_flush_ack", 32'(iq_if.ack_o), 32'd1);
    chk("post_flush_valid", 32'(deq_valid), 32'd0);
    tick();
    iq_if.ld_iq = 1'b0;
    chk("post_flush_valid_next", 32'(deq_valid), 32'd1);
    chk("post_flush_pc", deq_word.pc, 32'h100);
    chk("post_flush_count", 32'(count), 32'd1);

    // Reset and flush together
    flush_ip = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_flush_count", 32'(count), 32'd0);
    chk("rst_flush_empty", 32'(empty), 32'd1);
    rst = 1'b1;
    flush_ip = 1'b0;
    tick();
    chk("rst_flush_after", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
# instruction_queue

Circular FIFO between the instruction-decode stage and dispatch. Accepts one decoded `control_word` per cycle from the decoder over the `IQ_2_IR` interface, holds up to `DEPTH` entries in program order, and presents the oldest entry to dispatch with a valid/ready handshake. A pipeline flush empties it in one cycle.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`: pointer width; derived, not overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `iq_ir_itf`  modport `IQ_2_IR.IQ_SIG`  —  decoder side.
  - `ld_iq` (in) requests an enqueue.
  - `control_word` (in) is the entry to store.
  - `ack_o` (out) accepts the entry.
- `flush_ip`  in  1  flush in progress; clears the queue.
- `deq_rdy`  in  1  dispatch can take the head entry this cycle.
- `deq_valid`  out  1  head entry is valid.
- `deq_word`  out  `tomasula_types::control_word`  head entry (oldest).
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  PTR_W+1  current occupancy.

## Operation
- **State:**
  - `head` and `tail` pointers, each PTR_W bits; wrap from DEPTH-1 to 0 by natural overflow.
  - `count`, PTR_W+1 bits.
  - Storage array `q[DEPTH]` of `control_word`; storage is not reset.
- **Reset (`rst` low, asynchronous):** head=0, tail=0, count=0. Therefore `empty`=1, `full`=0, `deq_valid`=0, `ack_o`=0.
- **Enqueue:**
  - `ack_o = ld_iq & ~full & ~flush_ip`, combinational. The decoder samples it in the same cycle it raises `ld_iq`, and holds `ld_iq` and `control_word` stable until it sees `ack_o`.
  - On `ack_o`: `q[tail] <= control_word`, `tail <= tail+1`.
- **Dequeue:**
  - `deq_valid = ~empty`.
  - `deq_word = q[head]`, combinational read. When `deq_valid`=0, `deq_word` is don't-care.
  - `pop = deq_valid & deq_rdy & ~flush_ip`. On pop, `head <= head+1`.
- **Count:** `count <= count + ack_o - pop`. Simultaneous push and pop leaves count unchanged.
- **Full:** enqueue is refused even if a pop occurs in the same cycle; there is no full-bypass. `ack_o` rises the cycle after the first pop.
- **Empty:** there is no flow-through. An entry pushed at edge N is visible on `deq_valid` and `deq_word` after edge N.
- **Flush:**
  - While `flush_ip`=1, `ack_o`=0 and pop is suppressed.
  - On each edge with `flush_ip`=1: head=0, tail=0, count=0.
  - Entries offered during a flush are dropped.
- **Ordering:** strict FIFO. Entries leave in acceptance order, with no reordering and no duplication.
- **Illegal:** `deq_rdy` while empty is ignored. `ld_iq` while full is held off, not an error.

## Timing
- **Enqueue-to-visible latency:** 1 cycle.
- **Dequeue:** head advances at the edge where `pop`=1. The next entry appears combinationally after that edge.
- **Throughput:** one push and one pop per cycle, sustained. With `deq_rdy`=1 continuously and one push per cycle, occupancy stays at 1.
- **Combinational paths:**
  - `ld_iq` → `ack_o`.
  - `flush_ip` → `ack_o`.
  - `head`/storage → `deq_word`.
  - None from `deq_rdy` to any output.
- **Reset mid-operation:** all pointers clear immediately, asynchronously. Outputs reach their reset values with no clock.
- **Flush and reset together:** reset dominates; the result is identical.

## Structure
- `control_word` struct and `tomasula_types::op_t` live in the shared `tomasula_types` package. This block adds no new types.
- The `IQ_2_IR` interface gains nothing; this block uses the existing `IQ_SIG` modport (`ld_iq` in, `control_word` in, `ack_o` out).
- No sub-module. Storage is an inline register array. Pointer and count logic sit in one `always_ff` with async-low reset.
- Expected size: roughly 120–160 lines.

## Test plan
- **Reset:** drive `rst` low mid-run with count=5. Require, without a clock edge: `empty`=1, `count`=0, `deq_valid`=0, `ack_o`=0.
- **Fill and refuse:** DEPTH=8, `deq_rdy`=0, push `pc` values 0x04..0x20 step 4.
  - Require 8 acks and `full`=1.
  - On the 9th `ld_iq`, require `ack_o`=0.
  - Raise `deq_rdy` for 1 cycle; require `deq_word.pc`=0x04. Require `ack_o`=1 on the following cycle.
- **Ordering across wrap-around:** push and pop 20 words with random `deq_rdy` (50%). Require the pop sequence to equal the push sequence exactly, and `count` never above 8.
- **Simultaneous push/pop:** with count=3, assert `ld_iq` and `deq_rdy` together for 10 cycles. Require count=3 throughout and the head to advance each cycle.
- **Flush:** with count=6, raise `flush_ip` for 2 cycles with `ld_iq`=1 and `deq_rdy`=1.
  - Require `ack_o`=0 and no pops during the flush.
  - Require count=0 after the first edge.
  - After the flush, the next push (`pc`=0x100) must appear as `deq_word` one cycle later.
- **Empty latency:** from empty, push a word with `op`=JALR. Require `deq_valid`=0 in the push cycle and `deq_valid`=1 with `op`=JALR in the next cycle.
